// File: rtl/cia_seq_wide_adder_pkg.sv
// Shared definitions for the sequential slice-serial adder wrappers:
// slice width, FSM state encoding and slice-count derivation.
package cia_seq_wide_adder_pkg;

   localparam int unsigned SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned nslice_of(input int unsigned width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/CIAxbit.sv
// 16-bit carry-increment adder: 4-bit groups add with zero carry in parallel,
// then each group result is incremented by the carry rippling between groups.
module CIAxbit
   import cia_seq_wide_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               cin_i,
   output logic [SLICE_W-1:0] sum_o,
   output logic               cout_o
);

   localparam int unsigned GRP_W = 4;
   localparam int unsigned NGRP  = SLICE_W / GRP_W;

   logic [GRP_W:0]   grp_raw;
   logic [GRP_W-1:0] grp_inc;
   logic             c;

   always_comb begin
      sum_o   = '0;
      grp_raw = '0;
      grp_inc = '0;
      c       = cin_i;
      for (int unsigned g = 0; g < NGRP; g++) begin
         grp_raw = {1'b0, a_i[GRP_W*g +: GRP_W]} + {1'b0, b_i[GRP_W*g +: GRP_W]};
         grp_inc = grp_raw[GRP_W-1:0] + {{(GRP_W-1){1'b0}}, c};
         sum_o[GRP_W*g +: GRP_W] = grp_inc;
         // a raw group sum of all ones is the only case the increment can carry out
         c = grp_raw[GRP_W] | (c & (&grp_raw[GRP_W-1:0]));
      end
      cout_o = c;
   end

endmodule

// File: rtl/cia_seq_wide_adder.sv
// Slice-serial WIDTH-bit adder: one 16-bit CIAxbit slice per cycle, LSB first,
// with valid/ready handshakes on operand capture and result delivery.
module cia_seq_wide_adder
   import cia_seq_wide_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSLICE = nslice_of(WIDTH);
   localparam int unsigned IDXW   = $clog2(NSLICE);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [SLICE_W-1:0] slice_sum;
   logic              slice_cout;

   CIAxbit u_slice (
      .a_i    (a_q[SLICE_W*idx_q +: SLICE_W]),
      .b_i    (b_q[SLICE_W*idx_q +: SLICE_W]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDXW'(NSLICE-1)) begin
               state_d = DONE;
               cout_d  = slice_cout;
               // the top slice is being written this cycle, so its MSB is the result sign
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cia_seq_wide_adder.sv
// Directed bench for cia_seq_wide_adder (WIDTH=64): latency, handshakes,
// hold behaviour, reset abort and back-to-back issue.
module tb_cia_seq_wide_adder;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
   logic [W-1:0] a, b, sum;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   cia_seq_wide_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Issue one operand set from IDLE and return cycles until out_valid (0 on timeout).
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output int lat);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~av; b = ~bv; cin = ~cv;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      a = 64'h1; b = 64'h2; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({sum, cout, ovf, out_valid, in_ready} !== {64'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state: sum=%h cout=%b ovf=%b ov=%b ir=%b, want 0 0 0 0 1",
                  sum, cout, ovf, out_valid, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_no_capture: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic         vc [3];
      logic [W-1:0] es [3];
      logic         ec [3];
      logic         eo [3];
      int lat;
      va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
      es[0] = 64'h0; ec[0] = 1'b1; eo[0] = 1'b0;
      va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; vc[1] = 1'b0;
      es[1] = 64'h8000_0000_0000_0000; ec[1] = 1'b0; eo[1] = 1'b1;
      va[2] = 64'h0000_FFFF_0000_FFFF; vb[2] = 64'h0000_0001_0000_0001; vc[2] = 1'b1;
      es[2] = 64'h0001_0000_0001_0001; ec[2] = 1'b0; eo[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         do_op(va[k], vb[k], vc[k], lat);
         n_cmp++;
         if (lat != 4) begin
            n_bad++;
            $display("FAIL vec%0d_latency: got %0d want 4", k, lat);
         end
         n_cmp++;
         if ({sum, cout, ovf} !== {es[k], ec[k], eo[k]}) begin
            n_bad++;
            $display("FAIL vec%0d_result: sum=%h cout=%b ovf=%b want %h %b %b",
                     k, sum, cout, ovf, es[k], ec[k], eo[k]);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== es[k]) begin
            n_bad++;
            $display("FAIL vec%0d_release: ir=%b ov=%b sum=%h want 1 0 %h",
                     k, in_ready, out_valid, sum, es[k]);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      int bad = 0;
      do_op(64'h3, 64'h4, 1'b0, lat);
      n_cmp++;
      if (lat != 4) begin
         n_bad++;
         $display("FAIL hold_latency: got %0d want 4", lat);
      end
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 64'h7, 1'b0, 1'b0}) begin
            n_bad++; bad++;
            $display("FAIL hold_cycle%0d: ov=%b ir=%b sum=%h cout=%b ovf=%b want 1 0 7 0 0",
                     i, out_valid, in_ready, sum, cout, ovf);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || sum !== 64'h7) begin
         n_bad++;
         $display("FAIL hold_release: ir=%b sum=%h want 1 7", in_ready, sum);
      end
      // out_ready outside DONE must not disturb IDLE
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_out_ready: ir=%b ov=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int seen = 0;
      a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sum, cout, ovf, out_valid, in_ready} !== {64'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL abort_reset_state: sum=%h cout=%b ovf=%b ov=%b ir=%b want 0 0 0 0 1",
                  sum, cout, ovf, out_valid, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_cmp++;
      if (seen != 0 || sum !== 64'h0) begin
         n_bad++;
         $display("FAIL abort_no_valid: out_valid cycles=%0d sum=%h want 0 0", seen, sum);
      end
      do_op(64'd5, 64'd7, 1'b0, lat);
      n_cmp++;
      if (lat != 4 || {sum, cout, ovf} !== {64'd12, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL abort_next_op: lat=%0d sum=%h cout=%b ovf=%b want 4 c 0 0",
                  lat, sum, cout, ovf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oa [2];
      logic [W-1:0] ob [2];
      logic         oc [2];
      logic [W:0]   ref_full;
      logic         ref_ovf;
      int xfer_at [2];
      int cyc = 0, nx = 0, nres = 0;
      logic will_xfer;
      oa[0] = 64'h1234_5678_9ABC_DEF0; ob[0] = 64'h0FED_CBA9_8765_4321; oc[0] = 1'b1;
      oa[1] = 64'h8000_0000_0000_0000; ob[1] = 64'h8000_0000_0000_0000; oc[1] = 1'b0;
      xfer_at[0] = 0; xfer_at[1] = 0;
      a = oa[0]; b = ob[0]; cin = oc[0];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 40 && nres < 2; i++) begin
         if (out_valid) begin
            ref_full = {1'b0, oa[nres]} + {1'b0, ob[nres]} + {{W{1'b0}}, oc[nres]};
            ref_ovf  = (oa[nres][W-1] == ob[nres][W-1]) && (ref_full[W-1] != oa[nres][W-1]);
            n_cmp++;
            if ({cout, sum, ovf} !== {ref_full, ref_ovf}) begin
               n_bad++;
               $display("FAIL b2b_result%0d: cout=%b sum=%h ovf=%b want %b %h %b", nres,
                        cout, sum, ovf, ref_full[W], ref_full[W-1:0], ref_ovf);
            end
            nres++;
         end
         will_xfer = in_ready && in_valid;
         if (will_xfer) xfer_at[nx] = cyc + 1;
         @(posedge clk); cyc++; #1;
         if (will_xfer) begin
            nx++;
            if (nx < 2) begin a = oa[nx]; b = ob[nx]; cin = oc[nx]; end
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if (nres != 2 || nx != 2) begin
         n_bad++;
         $display("FAIL b2b_count: results=%0d transfers=%0d want 2 2", nres, nx);
      end
      n_cmp++;
      if (xfer_at[1] - xfer_at[0] != 6) begin
         n_bad++;
         $display("FAIL b2b_interval: got %0d want 6", xfer_at[1] - xfer_at[0]);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_hold();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
